vga_timing_counter: RTL and testbench
=====================================

// Module: vga_timing_counter
// PURPOSE
//   Generates the pixel-rate tick and the free-running horizontal/vertical scan
//   counters for the 640x480@60 display path. Its h_count/v_count outputs feed
//   vga_sync directly, which decodes them into h_sync, v_sync and video_on.
//   Also provides end-of-line and end-of-frame strobes and a frame counter.
// PARAMETERS
//   DIV  4    system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz pixel rate
//   HD   640  horizontal display pixels
//   HF   16   horizontal front porch
//   HB   48   horizontal back porch
//   HR   96   horizontal retrace
//   VD   480  vertical display lines
//   VF   10   vertical front porch
//   VB   33   vertical back porch
//   VR   2    vertical retrace
//   Derived: H_TOTAL = HD+HF+HB+HR = 800; V_TOTAL = VD+VF+VB+VR = 525
// PORTS
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   enable       in   1   run/hold; low freezes all counters
//   p_tick       out  1   pixel-rate strobe, one clk wide
//   h_count      out  10  horizontal position, 0..H_TOTAL-1
//   v_count      out  10  vertical position, 0..V_TOTAL-1
//   line_end     out  1   strobe: last pixel of a line
//   frame_end    out  1   strobe: last pixel of a frame
//   frame_count  out  8   completed frames, modulo 256
// BEHAVIOUR
//   - Reset (sync, has priority over enable): div_cnt, h_count, v_count and
//     frame_count load 0; p_tick, line_end and frame_end read 0 the cycle after.
//   - div_cnt counts 0..DIV-1 while enable=1 and wraps to 0; it holds while
//     enable=0.
//   - p_tick = enable && (div_cnt == DIV-1). Decode is from registered state
//     with no added latency. With DIV=1, p_tick = enable.
//   - h_count and v_count are registers. On an edge where p_tick=1:
//       * h_count increments.
//       * If h_count == H_TOTAL-1, h_count wraps to 0 and v_count increments.
//       * If v_count == V_TOTAL-1 at the same time, v_count wraps to 0.
//     Otherwise both counters hold.
//   - Each count value therefore lasts exactly DIV clks. p_tick marks the last
//     clk of that pixel period.
//   - line_end = p_tick && h_count == H_TOTAL-1.
//   - frame_end = line_end && v_count == V_TOTAL-1. frame_end implies line_end.
//   - frame_count increments on the edge where frame_end=1; 255 wraps to 0.
//   - enable low mid-pixel: the partial pixel period resumes from the held
//     div_cnt; no tick is lost or duplicated.
//   - Reset asserted mid-frame: the next edge zeroes everything. The first
//     p_tick after release comes DIV clks later.
//   - Counter values >= H_TOTAL / V_TOTAL are unreachable. No checking needed.
//   - Frame length = H_TOTAL*V_TOTAL*DIV clks = 1,680,000 at the defaults.
// STRUCTURE
//   - Package vga_timing_pkg holds HD..VR, H_TOTAL and V_TOTAL. It is shared
//     with vga_sync so porch and retrace values have one source.
//   - Sub-module pixel_tick_gen (params DIV; ports clk, reset, enable, p_tick)
//     holds div_cnt. The h/v counter chain and strobe logic stay in the top.
// TESTING
//   1. Reset, then enable=1, DIV=4:
//      -> p_tick first high on clk 4 after release (div_cnt=3).
//      -> h_count 0->1 on that edge; p_tick high every 4th clk thereafter.
//   2. Run 800 pixel periods:
//      -> line_end single pulse at h_count=799.
//      -> Next edge: h_count=0, v_count=1, frame_count still 0.
//   3. Run one full frame (1,680,000 clks):
//      -> frame_end pulses exactly once with h=799, v=524.
//      -> Next edge: h=0, v=0, frame_count=1.
//   4. enable=0 for 10 clks when div_cnt=2, h_count=37:
//      -> p_tick stays 0 and h_count stays 37.
//      -> After re-enable, p_tick comes 2 clks later (not 4).
//   5. Assert reset at h=500, v=300, frame_count=3:
//      -> Next edge: all counts 0, strobes 0.
//      -> Reset with enable=0 also clears.
//   6. Force 256 frames (DIV=1 build):
//      -> frame_count wraps 255->0.
//      -> p_tick constantly high while enabled.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : shared 640x480@60 porch/retrace constants and count type
// Rev 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HB = 48;
  localparam int HR = 96;
  localparam int VD = 480;
  localparam int VF = 10;
  localparam int VB = 33;
  localparam int VR = 2;

  localparam int H_TOTAL = HD + HF + HB + HR;
  localparam int V_TOTAL = VD + VF + VB + VR;

  localparam int COUNT_W = 10;
  typedef logic [COUNT_W-1:0] count_t;

endpackage
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// ============================================================================
// pixel_tick_gen : divides the system clock down to a one-clk pixel strobe
// Rev 1.0
// ============================================================================
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic p_tick
);

  // A 1-bit counter pinned at zero covers DIV=1, making p_tick follow enable.
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (enable) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign p_tick = enable && (div_cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_counter.sv
`default_nettype none
// ============================================================================
// vga_timing_counter : pixel tick, h/v scan counters, line/frame strobes
// Rev 1.0
// ============================================================================
module vga_timing_counter #(
  parameter int DIV = 4,
  parameter int HD  = vga_timing_pkg::HD,
  parameter int HF  = vga_timing_pkg::HF,
  parameter int HB  = vga_timing_pkg::HB,
  parameter int HR  = vga_timing_pkg::HR,
  parameter int VD  = vga_timing_pkg::VD,
  parameter int VF  = vga_timing_pkg::VF,
  parameter int VB  = vga_timing_pkg::VB,
  parameter int VR  = vga_timing_pkg::VR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       p_tick,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame_count
);
  import vga_timing_pkg::*;

  localparam int     H_TOTAL = HD + HF + HB + HR;
  localparam int     V_TOTAL = VD + VF + VB + VR;
  localparam count_t H_LAST  = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST  = count_t'(V_TOTAL - 1);

  count_t     h_count_q, h_count_d;
  count_t     v_count_q, v_count_d;
  logic [7:0] frame_count_q, frame_count_d;

  pixel_tick_gen #(
    .DIV    (DIV)
  ) u_pixel_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .p_tick (p_tick)
  );

  assign line_end  = p_tick && (h_count_q == H_LAST);
  assign frame_end = line_end && (v_count_q == V_LAST);

  always_comb begin
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_count_d = frame_count_q;
    if (p_tick) begin
      if (line_end) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + count_t'(1);
      end else begin
        h_count_d = h_count_q + count_t'(1);
      end
    end
    if (frame_end) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_count_q <= '0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_counter.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_counter : directed checks on a default DIV=4 build and a
// small DIV=1 build (12x10 raster, 120 clks per frame)
// Rev 1.0
// ============================================================================
module tb_vga_timing_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default 640x480 build, DIV=4
  logic       rst_a, en_a, pt_a, le_a, fe_a;
  logic [9:0] h_a, v_a;
  logic [7:0] fc_a;

  // Small raster build, DIV=1: H_TOTAL=12, V_TOTAL=10
  logic       rst_b, en_b, pt_b, le_b, fe_b;
  logic [9:0] h_b, v_b;
  logic [7:0] fc_b;

  vga_timing_counter #(.DIV(4)) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .p_tick(pt_a),
    .h_count(h_a), .v_count(v_a), .line_end(le_a), .frame_end(fe_a),
    .frame_count(fc_a)
  );

  vga_timing_counter #(
    .DIV(1), .HD(8), .HF(1), .HB(1), .HR(2), .VD(6), .VF(1), .VB(1), .VR(2)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .p_tick(pt_b),
    .h_count(h_b), .v_count(v_b), .line_end(le_b), .frame_end(fe_b),
    .frame_count(fc_b)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; en_a = 1'b1;
    step(1);
    checks++;
    if (h_a !== 10'd0 || v_a !== 10'd0 || fc_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: h=%0d v=%0d fc=%0d expected 0 0 0", h_a, v_a, fc_a);
    end
    checks++;
    if (pt_a !== 1'b0 || le_a !== 1'b0 || fe_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: pt=%b le=%b fe=%b expected 0 0 0", pt_a, le_a, fe_a);
    end
    rst_a = 1'b0;
  endtask

  task automatic test_first_tick;
    int ticks;
    step(2);
    checks++;
    if (pt_a !== 1'b0) begin
      errors++; $display("FAIL early_tick: pt=%b expected 0", pt_a);
    end
    step(1);
    checks++;
    if (pt_a !== 1'b1 || h_a !== 10'd0) begin
      errors++; $display("FAIL first_tick: pt=%b h=%0d expected 1 0", pt_a, h_a);
    end
    step(1);
    checks++;
    if (pt_a !== 1'b0 || h_a !== 10'd1) begin
      errors++; $display("FAIL after_first_tick: pt=%b h=%0d expected 0 1", pt_a, h_a);
    end
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (pt_a === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 3 || h_a !== 10'd4) begin
      errors++; $display("FAIL tick_rate: ticks=%0d h=%0d expected 3 4", ticks, h_a);
    end
  endtask

  task automatic test_line_end;
    int         pulses;
    logic [9:0] ph, pv;
    logic       pfe, done;
    pulses = 0; ph = '0; pv = '0; pfe = 1'b0; done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      step(1);
      if (le_a === 1'b1) begin
        pulses++; ph = h_a; pv = v_a; pfe = fe_a;
      end
      if (v_a === 10'd1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL line_timeout: v=%0d expected 1 within 4000 clks", v_a);
    end
    checks++;
    if (pulses != 1 || ph !== 10'd799 || pv !== 10'd0 || pfe !== 1'b0) begin
      errors++;
      $display("FAIL line_end_pulse: n=%0d h=%0d v=%0d fe=%b expected 1 799 0 0", pulses, ph, pv, pfe);
    end
    checks++;
    if (h_a !== 10'd0 || v_a !== 10'd1 || fc_a !== 8'd0) begin
      errors++;
      $display("FAIL line_wrap: h=%0d v=%0d fc=%0d expected 0 1 0", h_a, v_a, fc_a);
    end
  endtask

  task automatic test_enable_hold;
    int bad;
    step(37 * 4 + 2);
    checks++;
    if (h_a !== 10'd37) begin
      errors++; $display("FAIL hold_setup: h=%0d expected 37", h_a);
    end
    en_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (pt_a !== 1'b0 || h_a !== 10'd37) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_frozen: %0d bad cycles expected 0", bad);
    end
    en_a = 1'b1;
    step(1);
    checks++;
    if (pt_a !== 1'b1 || h_a !== 10'd37) begin
      errors++; $display("FAIL resume_tick: pt=%b h=%0d expected 1 37", pt_a, h_a);
    end
    step(1);
    checks++;
    if (pt_a !== 1'b0 || h_a !== 10'd38) begin
      errors++; $display("FAIL resume_adv: pt=%b h=%0d expected 0 38", pt_a, h_a);
    end
  endtask

  task automatic test_reset_mid_a;
    step(462 * 4);
    checks++;
    if (h_a !== 10'd500 || v_a !== 10'd1) begin
      errors++; $display("FAIL mid_setup_a: h=%0d v=%0d expected 500 1", h_a, v_a);
    end
    rst_a = 1'b1;
    step(1);
    checks++;
    if (h_a !== 10'd0 || v_a !== 10'd0 || fc_a !== 8'd0 ||
        pt_a !== 1'b0 || le_a !== 1'b0 || fe_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_a: h=%0d v=%0d fc=%0d pt=%b le=%b fe=%b expected all 0",
               h_a, v_a, fc_a, pt_a, le_a, fe_a);
    end
    rst_a = 1'b0;
    step(10);
    checks++;
    if (h_a !== 10'd2) begin
      errors++; $display("FAIL rerun_a: h=%0d expected 2", h_a);
    end
    en_a = 1'b0; rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    step(5);
    checks++;
    if (h_a !== 10'd0 || pt_a !== 1'b0) begin
      errors++; $display("FAIL reset_disabled_a: h=%0d pt=%b expected 0 0", h_a, pt_a);
    end
    en_a = 1'b1;
    step(2);
    checks++;
    if (pt_a !== 1'b0) begin
      errors++; $display("FAIL div_cleared_early: pt=%b expected 0", pt_a);
    end
    step(1);
    checks++;
    if (pt_a !== 1'b1 || h_a !== 10'd0) begin
      errors++; $display("FAIL div_cleared_tick: pt=%b h=%0d expected 1 0", pt_a, h_a);
    end
    en_a = 1'b0;
  endtask

  task automatic test_frame_end;
    int         pulses, fk, ptlow;
    logic [9:0] fh, fv;
    logic       fle, done;
    rst_b = 1'b1; en_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    checks++;
    if (h_b !== 10'd0 || v_b !== 10'd0 || fc_b !== 8'd0 || pt_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: h=%0d v=%0d fc=%0d pt=%b expected 0 0 0 1", h_b, v_b, fc_b, pt_b);
    end
    pulses = 0; fk = -1; ptlow = 0; fh = '0; fv = '0; fle = 1'b0; done = 1'b0;
    for (int k = 1; k <= 200 && !done; k++) begin
      step(1);
      if (pt_b !== 1'b1) ptlow++;
      if (fe_b === 1'b1) begin
        pulses++; fk = k; fh = h_b; fv = v_b; fle = le_b;
      end
      if (fc_b === 8'd1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL frame_timeout: fc=%0d expected 1 within 200 clks", fc_b);
    end
    checks++;
    if (pulses != 1 || fk != 119 || fh !== 10'd11 || fv !== 10'd9 || fle !== 1'b1) begin
      errors++;
      $display("FAIL frame_end_pulse: n=%0d at=%0d h=%0d v=%0d le=%b expected 1 119 11 9 1",
               pulses, fk, fh, fv, fle);
    end
    checks++;
    if (h_b !== 10'd0 || v_b !== 10'd0 || fc_b !== 8'd1 || ptlow != 0) begin
      errors++;
      $display("FAIL frame_wrap: h=%0d v=%0d fc=%0d ptlow=%0d expected 0 0 1 0", h_b, v_b, fc_b, ptlow);
    end
  endtask

  task automatic test_reset_mid_b;
    step(2 * 120 + 4 * 12 + 5);
    checks++;
    if (fc_b !== 8'd3 || v_b !== 10'd4 || h_b !== 10'd5) begin
      errors++; $display("FAIL mid_setup_b: fc=%0d v=%0d h=%0d expected 3 4 5", fc_b, v_b, h_b);
    end
    rst_b = 1'b1;
    step(1);
    checks++;
    if (h_b !== 10'd0 || v_b !== 10'd0 || fc_b !== 8'd0 || le_b !== 1'b0 || fe_b !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_b: h=%0d v=%0d fc=%0d le=%b fe=%b expected all 0", h_b, v_b, fc_b, le_b, fe_b);
    end
    rst_b = 1'b0;
    step(30);
    en_b = 1'b0; rst_b = 1'b1;
    step(1);
    checks++;
    if (h_b !== 10'd0 || v_b !== 10'd0 || pt_b !== 1'b0) begin
      errors++; $display("FAIL reset_disabled_b: h=%0d v=%0d pt=%b expected 0 0 0", h_b, v_b, pt_b);
    end
    rst_b = 1'b0; en_b = 1'b1;
  endtask

  task automatic test_frame_wrap;
    int ptlow, pulses;
    ptlow = 0;
    for (int i = 0; i < 255 * 120; i++) begin
      step(1);
      if (pt_b !== 1'b1) ptlow++;
    end
    checks++;
    if (fc_b !== 8'd255 || h_b !== 10'd0 || v_b !== 10'd0 || ptlow != 0) begin
      errors++;
      $display("FAIL pre_wrap: fc=%0d h=%0d v=%0d ptlow=%0d expected 255 0 0 0", fc_b, h_b, v_b, ptlow);
    end
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (fe_b === 1'b1) pulses++;
    end
    checks++;
    if (fc_b !== 8'd0 || pulses != 1) begin
      errors++; $display("FAIL fc_wrap: fc=%0d pulses=%0d expected 0 1", fc_b, pulses);
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    step(1);
    rst_b = 1'b0;
    test_reset;
    test_first_tick;
    test_line_end;
    test_enable_hold;
    test_reset_mid_a;
    test_frame_end;
    test_reset_mid_b;
    test_frame_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
